vram_fill_ctrl: RTL

//  Hardware rectangle-fill engine and write arbiter for the 32x32-cell video RAM write port.

---
 rtl/vram_fill_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vram_fill_ctrl.sv
// rtl/vram_fill_ctrl.sv - rectangle-fill engine and CPU-priority arbiter for the VRAM write port (option: VRAM_FILL_ABORT_EN)
module vram_fill_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int COORD_W    = 5,
    parameter int COLOR_W    = 3,
    parameter int ROW_STRIDE = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWe,
    input  logic [ADDR_W-1:0]  iCpuAddr,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iX0,
    input  logic [COORD_W-1:0] iY0,
    input  logic [COORD_W-1:0] iX1,
    input  logic [COORD_W-1:0] iY1,
    input  logic [COLOR_W-1:0] iColor,
`ifdef VRAM_FILL_ABORT_EN
    input  logic               iAbort,
`endif
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic               oVmWe,
    output logic [ADDR_W-1:0]  oVmAddr,
    output logic [COLOR_W-1:0] oVmColor
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state, state_n;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COLOR_W-1:0] color_q;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic               err_q;

    logic               abort_req;
    logic               rect_bad;
    logic               last_cell;
    logic               fill_grant;
    logic [ADDR_W-1:0]  fill_addr;

`ifdef VRAM_FILL_ABORT_EN
    assign abort_req = iAbort && ((state == ST_CHECK) || (state == ST_RUN));
`else
    assign abort_req = 1'b0;
`endif

    assign rect_bad   = (x0_q > x1_q) || (y0_q > y1_q);
    assign last_cell  = (cur_x == x1_q) && (cur_y == y1_q);
    // CPU owns the port whenever it asks; the cursor simply waits that cycle
    assign fill_grant = (state == ST_RUN) && !iCpuWe && !abort_req;
    // One spare bit of headroom in the multiply-add, then wrap into the VRAM space
    assign fill_addr  = ADDR_W'((ADDR_W+1)'(cur_y) * (ADDR_W+1)'(ROW_STRIDE) + (ADDR_W+1)'(cur_x));

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (iStart) state_n = ST_CHECK;
            ST_CHECK: state_n = (abort_req || rect_bad) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (abort_req)                    state_n = ST_DONE;
                else if (fill_grant && last_cell) state_n = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Command latch, cursor and error flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        x0_q    <= iX0;
                        y0_q    <= iY0;
                        x1_q    <= iX1;
                        y1_q    <= iY1;
                        color_q <= iColor;
                    end
                end
                ST_CHECK: begin
                    cur_x <= x0_q;
                    cur_y <= y0_q;
                    err_q <= abort_req || rect_bad;
                end
                ST_RUN: begin
                    if (abort_req) begin
                        err_q <= 1'b1;
                    end else if (fill_grant && !last_cell) begin
                        // Wrap to X0 before reaching X1+1, so X1 at max never overflows
                        if (cur_x == x1_q) begin
                            cur_x <= x0_q;
                            cur_y <= cur_y + 1'b1;
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                end
                ST_DONE: err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

    // Registered VRAM write port with CPU priority
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oVmWe    <= 1'b0;
            oVmAddr  <= '0;
            oVmColor <= '0;
        end else begin
            oVmWe <= 1'b0;
            if (iCpuWe) begin
                oVmWe    <= 1'b1;
                oVmAddr  <= iCpuAddr;
                oVmColor <= iCpuColor;
            end else if (fill_grant) begin
                oVmWe    <= 1'b1;
                oVmAddr  <= fill_addr;
                oVmColor <= color_q;
            end
        end
    end

    // Registered status; done trails the DONE state so it lands after the last write
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oError <= 1'b0;
        end else begin
            oBusy  <= (state_n != ST_IDLE);
            oDone  <= (state == ST_DONE);
            oError <= (state == ST_DONE) && err_q;
        end
    end

endmodule
